// File: rtl/yarp_pkg.sv
// Shared YARP core definitions: fetch FSM states, instruction width
// constants, default reset PC and PC alignment helpers.
package yarp_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/yarp_instr_fetch.sv
// YARP instruction fetch: owns the PC, issues one outstanding imem request
// at a time, hands each instruction and its PC to decode, and takes
// redirects from execute, dropping any response that a redirect superseded.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   imem_req_*          request channel (valid/ready, word address)
//   imem_rsp_*          response channel (one valid pulse per request)
//   redirect_i/_pc_i    taken branch/jump and its target
//   instr_*             instruction + PC to decode (valid/ready)
//   misaligned_o        sticky flag: a redirect target was not word aligned
module yarp_instr_fetch
    import yarp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        misaligned_o
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        misaligned_q;
    logic        capture;
    logic        req_valid;
    logic        hold_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
            pc    <= align_pc(RESET_PC);
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (capture) begin
            instr_q    <= imem_rsp_data_i;
            instr_pc_q <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (redirect_i && is_misaligned(redirect_pc_i)) begin
            misaligned_q <= 1'b1;
        end
    end

    // A redirect always wins the PC update; the state transitions below
    // only decide whether an in-flight response still has to be drained.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        req_valid  = 1'b0;
        hold_valid = 1'b0;

        unique case (state)
            S_REQ: begin
                req_valid = 1'b1;
                if (redirect_i) begin
                    state_next = imem_req_ready_i ? S_DROP : S_REQ;
                end else if (imem_req_ready_i) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    state_next = imem_rsp_valid_i ? S_REQ : S_DROP;
                end else if (imem_rsp_valid_i) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                hold_valid = 1'b1;
                if (redirect_i) begin
                    state_next = S_REQ;
                end else if (instr_ready_i) begin
                    pc_next    = pc + 32'(INSTR_BYTES);
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid_i) begin
                    state_next = S_REQ;
                end
            end
        endcase

        if (redirect_i) begin
            pc_next = align_pc(redirect_pc_i);
        end
    end

    assign imem_req_valid_o = req_valid & ~reset;
    assign imem_req_addr_o  = pc;
    assign instr_valid_o    = hold_valid & ~reset;
    assign instr_o          = instr_q;
    assign instr_pc_o       = instr_pc_q;
    assign misaligned_o     = misaligned_q;

endmodule

// File: tb/tb_yarp_instr_fetch.sv
// Self-checking bench for yarp_instr_fetch: directed scenarios plus a
// randomized phase checked against an architectural PC / memory model.
module tb_yarp_instr_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        misaligned_o;

    yarp_instr_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .misaligned_o     (misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: architectural PC, sticky flag, memory model.
    logic [31:0] exp_pc;
    bit          exp_mis;
    bit          outst;
    logic [31:0] out_addr;
    int          cnt;
    int          lat;
    bit          nop_mode;

    int checks;
    int errors;
    int cyc;
    int idle;
    int hs_cnt;
    int nfire;
    int base;
    int n_c;
    logic [31:0] hs_pcs[$];
    logic [31:0] fire_addr[$];
    int          fire_cyc[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        if (nop_mode) return 32'h0000_0013;
        return (a ^ 32'h5A5A_0013) + {a[9:2], 24'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit rr, input bit ir, input bit rd,
                        input logic [31:0] rt);
        bit          rsp;
        bit          fire;
        bit          hs;
        logic [31:0] addr_s;
        logic [31:0] pc_s;
        imem_req_ready_i = rr;
        instr_ready_i    = ir;
        redirect_i       = rd;
        redirect_pc_i    = rt;
        if (reset) rsp = 1'($urandom_range(0, 1));
        else       rsp = outst && cnt == 0;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = (rsp && !reset) ? word(out_addr) : $urandom;
        @(negedge clk);
        cyc++;
        addr_s = imem_req_addr_o;
        pc_s   = instr_pc_o;
        if (!reset) begin
            chk("both_valid", 32'(imem_req_valid_o & instr_valid_o), 0);
            chk("misaligned", 32'(misaligned_o), 32'(exp_mis));
            if (imem_req_valid_o) begin
                chk("req_addr", addr_s, exp_pc);
                chk("one_outstanding", 32'(outst), 0);
            end
            if (instr_valid_o) begin
                chk("instr_pc", pc_s, exp_pc);
                chk("instr", instr_o, word(exp_pc));
            end
        end else begin
            chk("rst_req_valid", 32'(imem_req_valid_o), 0);
            chk("rst_instr_valid", 32'(instr_valid_o), 0);
        end
        fire = !reset && imem_req_valid_o && rr;
        hs   = !reset && instr_valid_o && ir;
        @(posedge clk);
        #1;
        if (reset) begin
            exp_pc  = 32'h0;
            exp_mis = 0;
            outst   = 0;
        end else begin
            if (rsp) outst = 0;
            else if (outst) cnt--;
            if (fire) begin
                outst    = 1;
                out_addr = addr_s;
                cnt      = lat;
                fire_cyc.push_back(cyc);
                fire_addr.push_back(addr_s);
            end
            if (hs) begin
                hs_cnt++;
                hs_pcs.push_back(pc_s);
            end
            if (rd) begin
                exp_pc = {rt[31:2], 2'b00};
                if (rt[1:0] != 2'b00) exp_mis = 1;
            end else if (hs) begin
                exp_pc = exp_pc + 32'd4;
            end
            if (fire || hs) idle = 0;
            else idle++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick(0, 0, 0, 32'h0);
        reset = 1'b0;
        cyc    = 0;
        hs_cnt = 0;
        idle   = 0;
        hs_pcs.delete();
        fire_addr.delete();
        fire_cyc.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        lat = 0;
        nop_mode = 1;
        exp_pc = 0;
        exp_mis = 0;
        outst = 0;
        cnt = 0;
        reset = 1'b1;
        imem_req_ready_i = 0;
        imem_rsp_valid_i = 0;
        imem_rsp_data_i = 0;
        redirect_i = 0;
        redirect_pc_i = 0;
        instr_ready_i = 0;

        // Zero-wait memory, decode always ready.
        do_reset();
        chk("rst_instr_o", instr_o, 0);
        chk("rst_instr_pc", instr_pc_o, 0);
        chk("rst_mis", 32'(misaligned_o), 0);
        repeat (9) tick(1, 1, 0, 32'h0);
        chk("n_fire", fire_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("fire_cyc", i < fire_cyc.size() ? fire_cyc[i] : -1,
                1 + 3 * i);
            chk("fire_addr", i < fire_addr.size() ? fire_addr[i] : 'x,
                32'(4 * i));
            chk("hs_pc", i < hs_pcs.size() ? hs_pcs[i] : 'x, 32'(4 * i));
        end

        // Memory and decode back-pressure.
        do_reset();
        repeat (3) tick(1, 1, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 32'h0);
            chk("stall_valid", 32'(imem_req_valid_o), 1);
            chk("stall_addr", imem_req_addr_o, 32'h4);
        end
        tick(1, 0, 0, 32'h0);
        tick(0, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 0, 32'h0);
            chk("hold_valid", 32'(instr_valid_o), 1);
            chk("hold_pc", instr_pc_o, 32'h4);
            chk("hold_instr", instr_o, 32'h13);
        end
        tick(0, 1, 0, 32'h0);
        chk("no_dup", fire_addr.size(), 2);

        // Redirect while waiting on the response for 0x8.
        lat = 2;
        tick(1, 1, 0, 32'h0);
        lat = 0;
        tick(0, 1, 1, 32'h100);
        base  = hs_cnt;
        nfire = fire_addr.size();
        for (int k = 0; k < 20 && hs_cnt == base; k++)
            tick(1, 1, 0, 32'h0);
        chk("redir_fire", nfire < fire_addr.size() ? fire_addr[nfire] : 'x,
            32'h100);
        chk("redir_hs", base < hs_pcs.size() ? hs_pcs[base] : 'x, 32'h100);
        n_c = 0;
        foreach (hs_pcs[i]) if (hs_pcs[i] == 32'h8) n_c++;
        chk("stale_dropped", n_c, 0);

        // Redirect coincident with the handshake at 0xC.
        do_reset();
        repeat (11) tick(1, 1, 0, 32'h0);
        chk("at_c_valid", 32'(instr_valid_o), 1);
        tick(0, 1, 1, 32'h200);
        chk("hs_redir_valid", 32'(imem_req_valid_o), 1);
        chk("hs_redir_addr", imem_req_addr_o, 32'h200);
        n_c = 0;
        foreach (hs_pcs[i]) if (hs_pcs[i] == 32'hC) n_c++;
        chk("c_once", n_c, 1);
        repeat (2) tick(1, 1, 0, 32'h0);

        // Misaligned redirect target.
        tick(0, 0, 1, 32'h302);
        chk("mis_set", 32'(misaligned_o), 1);
        chk("mis_addr", imem_req_addr_o, 32'h300);
        repeat (6) tick(1, 1, 0, 32'h0);
        chk("mis_sticky", 32'(misaligned_o), 1);
        do_reset();
        chk("mis_clear", 32'(misaligned_o), 0);

        // PC wrap, then reset while holding an instruction.
        tick(0, 1, 1, 32'hFFFF_FFFC);
        repeat (3) tick(1, 1, 0, 32'h0);
        chk("wrap_hs", hs_pcs.size() > 0 ? hs_pcs[hs_pcs.size() - 1] : 'x,
            32'hFFFF_FFFC);
        chk("wrap_addr", imem_req_addr_o, 32'h0);
        repeat (3) tick(1, 1, 0, 32'h0);
        tick(1, 0, 0, 32'h0);
        tick(1, 0, 0, 32'h0);
        chk("pre_rst_hold", 32'(instr_valid_o), 1);
        chk("pre_rst_pc", instr_pc_o, 32'h4);
        reset = 1'b1;
        tick(0, 0, 0, 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ivalid", 32'(instr_valid_o), 0);
        chk("post_rst_rvalid", 32'(imem_req_valid_o), 1);
        chk("post_rst_addr", imem_req_addr_o, 32'h0);

        // Randomized traffic against the reference model.
        nop_mode = 0;
        hs_cnt = 0;
        idle = 0;
        for (int n = 0; n < 3000; n++) begin
            bit          rd;
            logic [31:0] rt;
            lat   = $urandom_range(0, 3);
            reset = ($urandom_range(0, 299) == 0);
            rd    = !reset && ($urandom_range(0, 11) == 0);
            rt    = $urandom;
            if ($urandom_range(0, 1) == 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rd, rt);
            if (idle > 60) begin
                chk("watchdog", idle, 0);
                break;
            end
        end
        reset = 1'b0;
        chk("progress", 32'(hs_cnt > 100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/yarp_instr_fetch.md
Name: yarp_instr_fetch

Overview:
- Front end of the YARP core. Owns the program counter and issues single-outstanding instruction-memory requests over a valid/ready interface.
- Presents each fetched instruction and its PC to decode with a valid/ready handshake.
- Consumes the branch/jump outcome from execute as a redirect. Discards stale in-flight fetches after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- imem_req_valid_o  output  1  fetch request valid
- imem_req_ready_i  input  1  memory accepts request this cycle
- imem_req_addr_o  output  32  fetch address (word aligned)
- imem_rsp_valid_i  input  1  response data valid (exactly one per accepted request, ≥1 cycle after acceptance)
- imem_rsp_data_i  input  32  fetched instruction word
- redirect_i  input  1  taken branch or jump from execute
- redirect_pc_i  input  32  redirect target
- instr_valid_o  output  1  instruction available to decode
- instr_ready_i  input  1  decode accepts instruction
- instr_o  output  32  instruction word
- instr_pc_o  output  32  PC of instr_o
- misaligned_o  output  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - pc = RESET_PC; state = S_REQ.
  - imem_req_valid_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, misaligned_o = 0.
  - While reset is high, all valid outputs are forced to 0.
- States:
  - S_REQ: imem_req_valid_o = 1, imem_req_addr_o = pc.
    - req_ready high → S_WAIT.
    - Otherwise hold; the address stays stable while valid is high and unaccepted.
  - S_WAIT: no request.
    - rsp_valid high → latch instr_o = rsp_data, instr_pc_o = pc → S_HOLD.
  - S_HOLD: instr_valid_o = 1; instr_o and instr_pc_o are held stable.
    - instr_ready high → pc <= pc + 4 → S_REQ.
  - S_DROP: waits for the response of a superseded request.
    - rsp_valid high → discard data → S_REQ.
- Latency:
  - First request is asserted in the first cycle after reset deasserts.
  - With zero memory wait, instr_valid_o rises the cycle after rsp_valid.
  - Steady state is 1 instruction per 3 cycles minimum.
- Redirect (redirect_i high) overrides every other pc update. pc <= {redirect_pc_i[31:2], 2'b00}. If redirect_pc_i[1:0] != 0, misaligned_o sets and stays 1 until reset.
  - S_REQ, request not accepted this cycle: → S_REQ with the new pc. The request is withdrawn; this is the one permitted change of address while valid.
  - S_REQ, request accepted the same cycle: → S_DROP.
  - S_WAIT, no rsp this cycle: → S_DROP.
  - S_WAIT, rsp the same cycle: data dropped, → S_REQ. instr_valid_o never rises for it.
  - S_HOLD: instr_valid_o deasserts next cycle, → S_REQ. A simultaneous instr_ready handshake counts as accepted; pc still takes the redirect target, not +4.
  - S_DROP: pc updated; stays S_DROP. If rsp arrives the same cycle → S_REQ.
- Width rules:
  - pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).
  - imem_req_addr_o[1:0] is always 0.
- Reset mid-operation:
  - Any state → S_REQ next cycle, pc = RESET_PC, instr_valid_o drops.
  - Instruction memory shares this reset and abandons outstanding responses.
  - A response asserted during reset is ignored.
- Invariants:
  - At most one outstanding request.
  - instr_valid_o and imem_req_valid_o are never high together.

Decomposition:
- yarp_pkg gains:
  - fetch_state_t enum {S_REQ, S_WAIT, S_HOLD, S_DROP}
  - localparam INSTR_BYTES = 4
  - default RESET_PC constant
- No sub-module: PC register, FSM and output register are kept in one module.

Test Plan:
- Reset, zero-wait memory returning 32'h0000_0013 for every address, decode always ready → requests at 0x0, 0x4, 0x8 every 3 cycles; instr_pc_o matches each; first request in cycle 1 after reset.
- Memory holds req_ready low 3 cycles, decode holds instr_ready low 2 cycles → imem_req_addr_o stable at 0x4 throughout; instr_o/instr_pc_o stable while instr_valid_o high; no duplicate request.
- Redirect to 0x100 while in S_WAIT for 0x8, response 2 cycles later → that response is never presented; next request addr 0x100; following presented instr_pc_o = 0x100.
- Redirect to 0x200 coincident with an instr_valid/instr_ready handshake at pc 0xC → 0xC consumed once; next request 0x200, not 0x10.
- Redirect to 0x302 → misaligned_o = 1 and stays set; request addr 0x300; reset clears misaligned_o.
- pc at 0xFFFF_FFFC accepted by decode → next request 0x0000_0000; reset asserted in S_HOLD → instr_valid_o 0 next cycle, next request RESET_PC.
